mips_fetch_queue: RTL

Instruction prefetch stage sitting between the instruction memory and the decode pipeline register of the 5-stage MIPS core.
- Generates sequential fetch addresses and issues requests over a req/gnt, in-order rvalid memory interface.
- Buffers returned instructions with their PC and PC+4 in a FIFO, presented to decode with a valid/ready handshake.
- Honours branch/jump redirects by flushing queued entries and discarding in-flight responses.

---
 rtl/mips_fetch_queue.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mips_fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches, tags them with their PC,
// buffers responses for decode and flushes on redirect. Optional macro: FQ_BYPASS_EN.
module mips_fetch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [31:0]              dec_instr,
    output logic [31:0]              dec_pc,
    output logic [31:0]              dec_pc_plus4,
    output logic [$clog2(DEPTH):0]   fq_count
);
    // state | meaning
    // RUN   | normal operation, every response is kept
    // FLUSH | drop_cnt > 0, responses to pre-redirect requests are discarded
    typedef enum logic {RUN, FLUSH} state_e;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
    logic [31:0]     tag_pc_q [MAX_OUTSTANDING];
    logic [31:0]     tag_pc_d [MAX_OUTSTANDING];
    logic [TW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [31:0]     fifo_instr_q [DEPTH];
    logic [31:0]     fifo_instr_d [DEPTH];
    logic [31:0]     fifo_pc_q [DEPTH];
    logic [31:0]     fifo_pc_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            issue, rsp_drop, bypass, fifo_empty, fifo_push, fifo_pop;
    logic [31:0]     rsp_tag;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        if (32'(p) >= MAX_OUTSTANDING - 1) return '0;
        return p + TW'(1);
    endfunction

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        tag_pc_d      = tag_pc_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        fifo_instr_d  = fifo_instr_q;
        fifo_pc_d     = fifo_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        // Credit counts every granted request, including ones that will be dropped.
        imem_req  = !rst && !redirect_valid
                    && ((32'(count_q) + 32'(outstanding_q)) < DEPTH)
                    && (32'(outstanding_q) < MAX_OUTSTANDING);
        imem_addr = fetch_pc_q;
        issue     = imem_req && imem_gnt;
        rsp_tag   = tag_pc_q[tag_rd_q];
        rsp_drop  = imem_rvalid && (redirect_valid || drop_cnt_q != '0);
        fifo_empty = (count_q == '0);
`ifdef FQ_BYPASS_EN
        bypass = !rst && !redirect_valid && fifo_empty && state_q == RUN
                 && drop_cnt_q == '0 && imem_rvalid && dec_ready;
`else
        bypass = 1'b0;
`endif
        fifo_pop  = !fifo_empty && dec_ready;
        fifo_push = imem_rvalid && !rsp_drop && !bypass;

        if (issue) begin
            fetch_pc_d         = fetch_pc_q + 32'd4;
            tag_pc_d[tag_wr_q] = fetch_pc_q;
            tag_wr_d           = tag_inc(tag_wr_q);
        end
        if (imem_rvalid) tag_rd_d = tag_inc(tag_rd_q);
        outstanding_d = outstanding_q + OW'(issue) - OW'(imem_rvalid);

        if (fifo_push) begin
            fifo_instr_d[wr_ptr_q] = imem_rdata;
            fifo_pc_d[wr_ptr_q]    = rsp_tag;
            wr_ptr_d               = wr_ptr_q + AW'(1);
        end
        if (fifo_pop) rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(fifo_push) - CW'(fifo_pop);

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = outstanding_d;
            state_d    = (outstanding_d != '0) ? FLUSH : RUN;
        end else begin
            if (imem_rvalid && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - OW'(1);
            case (state_q)
                RUN:     state_d = RUN;
                FLUSH:   if (drop_cnt_d == '0) state_d = RUN;
                default: state_d = RUN;
            endcase
        end

        dec_valid = !fifo_empty || bypass;
        if (bypass) begin
            dec_instr = imem_rdata;
            dec_pc    = rsp_tag;
        end else if (!fifo_empty) begin
            dec_instr = fifo_instr_q[rd_ptr_q];
            dec_pc    = fifo_pc_q[rd_ptr_q];
        end else begin
            dec_instr = '0;
            dec_pc    = '0;
        end
        dec_pc_plus4 = dec_valid ? dec_pc + 32'd4 : '0;
        fq_count     = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Payload storage needs no reset; validity lives in count_q.
    always_ff @(posedge clk) begin
        tag_pc_q     <= tag_pc_d;
        fifo_instr_q <= fifo_instr_d;
        fifo_pc_q    <= fifo_pc_d;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(fifo_push && !fifo_pop && count_q == CW'(DEPTH)));
    a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid && outstanding_q == '0));

endmodule
